// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: one-shot with held irq, or auto-reload with a one-cycle irq pulse.
// Optional prescaler in CTRL[15:8] is built when TIMER_PRESCALE_EN is defined.
`timescale 1ns/1ps
module timer_dev #(
  parameter logic [31:0] RESET_PRESET = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state_reg;
  logic        en_reg;
  logic [1:0]  mode_reg;
  logic        im_reg;
  logic [31:0] preset_reg;
  logic [31:0] count_reg;
  logic        pend_reg;
  logic        irq_reg;
  logic        pend_next;
  logic        im_next;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        tick;
  logic        expire;
  logic [31:0] ctrl_rd;
  logic        unused_wd;

  assign ctrl_wr   = write_enable && (addr == 2'd0);
  assign preset_wr = write_enable && (addr == 2'd1);
  assign expire    = (state_reg == CNT) && en_reg && tick && (count_reg <= 32'd1);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] psc_reg;
  logic [7:0] psc_cnt_reg;

  assign tick      = (psc_cnt_reg == psc_reg);
  assign ctrl_rd   = {16'd0, psc_reg, 4'd0, im_reg, mode_reg, en_reg};
  assign unused_wd = ^{write_data[31:16], write_data[7:4]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_reg     <= 8'd0;
      psc_cnt_reg <= 8'd0;
    end else begin
      if (ctrl_wr)
        psc_reg <= write_data[15:8];
      // Free-runs only while counting; LOAD, IDLE and EN=0 all restart the divider.
      if (state_reg == CNT && en_reg)
        psc_cnt_reg <= tick ? 8'd0 : psc_cnt_reg + 8'd1;
      else
        psc_cnt_reg <= 8'd0;
    end
  end
`else
  assign tick      = 1'b1;
  assign ctrl_rd   = {28'd0, im_reg, mode_reg, en_reg};
  assign unused_wd = ^write_data[31:4];
`endif

  // The CPU write to CTRL has the last word on pend, so it beats both set and clear.
  always_comb begin
    pend_next = pend_reg;
    if (expire)
      pend_next = 1'b1;
    if (state_reg == INT && mode_reg == 2'b01)
      pend_next = 1'b0;
    if (ctrl_wr)
      pend_next = 1'b0;
  end

  assign im_next = ctrl_wr ? write_data[3] : im_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      en_reg     <= 1'b0;
      mode_reg   <= 2'b00;
      im_reg     <= 1'b0;
      preset_reg <= RESET_PRESET;
      count_reg  <= 32'd0;
      pend_reg   <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      irq_reg  <= pend_next & im_next;
      if (preset_wr)
        preset_reg <= write_data;
      case (state_reg)
        IDLE: if (en_reg) state_reg <= LOAD;
        LOAD: begin
          count_reg <= preset_reg;
          state_reg <= CNT;
        end
        CNT: begin
          if (!en_reg) begin
            state_reg <= IDLE;
          end else if (tick) begin
            if (count_reg <= 32'd1) begin
              count_reg <= 32'd0;
              state_reg <= INT;
            end else begin
              count_reg <= count_reg - 32'd1;
            end
          end
        end
        INT: begin
          if (mode_reg == 2'b01) begin
            state_reg <= LOAD;
          end else begin
            en_reg    <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // Placed after the FSM so a same-cycle CPU write overrides the INT-state EN clear.
      if (ctrl_wr) begin
        en_reg   <= write_data[0];
        mode_reg <= write_data[2:1];
        im_reg   <= write_data[3];
      end
    end
  end

  always_comb begin
    case (addr)
      2'd0:    read_result = ctrl_rd;
      2'd1:    read_result = preset_reg;
      2'd2:    read_result = count_reg;
      default: read_result = 32'd0;
    endcase
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_timer_dev.sv
// Randomized scenarios against a timeline model of the timer; a monitor pops expected reads from a queue.
`timescale 1ns/1ps
module tb_timer_dev;

  localparam logic [31:0] RP = 32'h0000_00A5;
  localparam int NONE = 100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        write_enable = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_result;
  logic        irq;

  always #5 clk = ~clk;

  timer_dev #(.RESET_PRESET(RP)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .write_enable(write_enable),
    .write_data(write_data),
    .read_result(read_result),
    .irq(irq)
  );

  typedef struct {
    logic [1:0]  a;
    logic [31:0] data;
    logic        irq;
    int          s;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Scenario parameters; edge 0 is the edge that writes EN=1.
  int          n0, n1, p, w, len;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] c0, c2;
  bit          coll;

  // Timeline model: first load at edge 2, expiry max(N,1) edges later, reload two edges after expiry.
  function automatic void model(input int s, output logic [31:0] r_ctrl, output logic [31:0] r_preset,
                                output logic [31:0] r_count, output logic r_irq);
    int l, e, n, cnt;
    logic en_b, pend_b;
    r_preset = (s >= p) ? 32'(n1) : 32'(n0);
    en_b = 1'b1;
    pend_b = 1'b0;
    cnt = 0;
    if (s < 0) begin
      r_ctrl = 32'd0;
      r_count = 32'd0;
      r_irq = 1'b0;
      return;
    end
    l = 2;
    n = (p < l) ? n1 : n0;
    for (int k = 0; k < 1000; k++) begin
      e = l + ((n > 1) ? n : 1);
      if (s < l) begin cnt = 0; break; end
      if (s < e) begin cnt = n - (s - l); break; end
      if (s == e) begin cnt = 0; pend_b = 1'b1; break; end
      if (mode != 2'b01) begin cnt = 0; pend_b = 1'b1; en_b = 1'b0; break; end
      if (s == e + 1) begin cnt = 0; break; end
      l = e + 2;
      n = (p < l) ? n1 : n0;
    end
    r_ctrl = {28'd0, im, mode, en_b};
    if (s >= w) begin
      r_ctrl = {28'd0, c2[3:0]};
      pend_b = 1'b0;
    end
    r_count = 32'(cnt);
    r_irq = pend_b & r_ctrl[3];
  endfunction

  task automatic push_exp(input logic [1:0] a, input logic [31:0] d, input logic i, input int s);
    exp_t x;
    x.a = a;
    x.data = d;
    x.irq = i;
    x.s = s;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_cmp++;
      if (read_result !== x.data) begin
        n_bad++;
        $display("FAIL read a=%0d s=%0d got %h want %h", x.a, x.s, read_result, x.data);
      end
      n_cmp++;
      if (irq !== x.irq) begin
        n_bad++;
        $display("FAIL irq s=%0d got %b want %b", x.s, irq, x.irq);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ec, ep, en;
    logic ei;
    int e0;
    repeat (2) @(posedge clk);
    #1;
    for (int sc = 0; sc < 40; sc++) begin
      // Reset asserted asynchronously, usually with the previous scenario still counting.
      rst = 1'b0;
      write_enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
        addr = 2'(i);
        push_exp(2'(i), (i == 1) ? RP : 32'd0, 1'b0, -100 + i);
        @(posedge clk);
        #1;
      end
      rst = 1'b1;

      mode = 2'($urandom_range(0, 3));
      im   = ($urandom_range(0, 3) != 0);
      n0   = $urandom_range(0, 12);
      n1   = $urandom_range(0, 12);
      c0   = ($urandom & 32'hFFFF_00F0) | {28'd0, im, mode, 1'b1};
      e0   = 2 + ((n0 > 1) ? n0 : 1);
      p    = ($urandom_range(0, 1) != 0) ? $urandom_range(3, e0 + 10) : NONE;
      coll = 1'b0;
      c2   = 32'd0;
      if (mode == 2'b01) begin
        w   = NONE;
        len = e0 + $urandom_range(1, 42);
      end else begin
        coll = ($urandom_range(0, 3) == 0);
        w    = coll ? e0 + 1 : e0 + $urandom_range(2, 5);
        c2   = ($urandom & 32'hFFFF_00F0) | {28'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), coll};
        len  = coll ? w + 2 : w + 4;
        if (p == w) p = NONE;
      end

      addr = 2'd1;
      write_enable = 1'b1;
      write_data = 32'(n0);
      push_exp(2'd1, RP, 1'b0, -2);
      @(posedge clk);
      #1;

      for (int s = -1; s < len; s++) begin
        if (s + 1 == 0) begin
          write_enable = 1'b1; addr = 2'd0; write_data = c0;
        end else if (s + 1 == p) begin
          write_enable = 1'b1; addr = 2'd1; write_data = 32'(n1);
        end else if (s + 1 == w) begin
          write_enable = 1'b1; addr = 2'd0; write_data = c2;
        end else begin
          write_enable = 1'b0; addr = 2'($urandom_range(0, 3));
        end
        model(s, ec, ep, en, ei);
        case (addr)
          2'd0:    push_exp(addr, ec, ei, s);
          2'd1:    push_exp(addr, ep, ei, s);
          2'd2:    push_exp(addr, en, ei, s);
          default: push_exp(addr, 32'd0, ei, s);
        endcase
        @(posedge clk);
        #1;
      end
      write_enable = 1'b0;
      $display("scenario %0d mode=%0d im=%0d n0=%0d n1=%0d p=%0d w=%0d coll=%0d len=%0d",
               sc, mode, im, n0, n1, p, w, coll, len);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer device that sits behind the bridge.
- The bridge decodes the timer's address window, forwards word writes, and muxes this block's read data into the CPU read path.
- The block's irq output drives one hwirq line into the CPU.
- Two modes: one-shot with a held interrupt, and auto-reload with a one-cycle interrupt pulse.

Parameters:
- RESET_PRESET, 32'd0, reset value of the PRESET register.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- addr  input  2  word select, driven from CPU address bits [3:2].
- write_enable  input  1  word write strobe, already qualified by the bridge decode.
- write_data  input  32  store data.
- read_result  output  32  combinational read data for the selected register.
- irq  output  1  interrupt request to the bridge hwirq.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0, everything is cleared: ctrl=0, preset=RESET_PRESET, count=0, pend=0, state=IDLE, irq=0. When reset asserts mid-count, the count aborts immediately.
- Register map (byte offsets):
  - 0x0 CTRL: bit0 EN, bits[2:1] MODE, bit3 IM. All other bits are write-ignored and read 0.
  - 0x4 PRESET: read/write.
  - 0x8 COUNT: read-only; writes are ignored.
  - 0xC: reads 0, writes ignored.
- Reads: combinational from addr; no wait states.
- Writes: take effect at the clk edge where write_enable=1.
- Any write to CTRL clears pend.
- A write to PRESET while counting does not disturb count; the new value is used at the next LOAD.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1 go to LOAD, else stay.
  - LOAD: count<=preset; go to CNT.
  - CNT, EN=0: go to IDLE; count holds its value.
  - CNT, tick and count<=1: count<=0, pend<=1, go to INT.
  - CNT, tick and count>1: count<=count-1.
  - INT, MODE=01: pend<=0, go to LOAD. The irq pulse is exactly one cycle.
  - INT, any other MODE (00, and 10/11 treated as 00): EN<=0, go to IDLE. pend holds until software writes CTRL.
- Simultaneous CPU write to CTRL and FSM EN-clear in INT: the CPU write wins, both for EN and for pend.
- irq = pend & IM, registered.
- tick = 1 every cycle unless the optional feature is enabled.
- Latency: after EN is written at edge t, pend is set at edge t+2+max(N,1), where N = preset. Preset 0 and preset 1 behave identically.
- Auto-reload period: preset+2 cycles, i.e. INT plus LOAD overhead.
- Counter arithmetic is 32-bit unsigned. Count never wraps below 0.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- When defined:
  - CTRL bits[15:8] form a writable field PSC. It reads back its written value.
  - An 8-bit prescaler counter is cleared in LOAD and when EN=0.
  - tick asserts once every PSC+1 cycles in CNT, so PSC=0 behaves exactly like the feature being absent.
- When undefined: bits[15:8] read 0, no prescaler logic exists, and tick=1.

Test Plan:
1. Reset: assert rst=0 mid-count with preset=100 -> read_result=0 for CTRL and COUNT, PRESET=RESET_PRESET, irq=0 immediately. After release, state is IDLE.
2. One-shot: preset=3, then CTRL=0x9 (EN, mode 0, IM) at edge t -> COUNT reads 3,2,1,0. irq rises after edge t+5 and stays high. EN reads 0. A write of CTRL=0x8 drops irq on the next edge.
3. Auto-reload: preset=4, CTRL=0xB -> irq is a single-cycle pulse every 6 cycles, 5 consecutive pulses. EN stays 1.
4. Masking: preset=2, CTRL=0x1 (IM=0) -> irq stays 0, CTRL EN reads 0 after expiry. Then CTRL=0x8 -> irq remains 0, because the CTRL write clears pend.
5. Collisions: write PRESET=50 during a count from 10 -> first expiry after 10 ticks, next reload uses 50 (mode 1). A CTRL write landing on the INT cycle in mode 0 -> the written EN value is retained.
6. With TIMER_PRESCALE_EN: preset=2, PSC=3, CTRL=0x309 -> COUNT decrements every 4 cycles. Expiry occurs 8 tick-cycles after LOAD. Reading CTRL returns 0x309.
